uart_cmd_sequencer: RTL and testbench

Command-level controller that sits directly behind the UART receiver and sequences the raw byte stream from the MATLAB GUI into validated register-write commands. It frames bytes as sync/address/data/checksum, verifies the checksum and enforces an inter-byte timeout. It presents each accepted command on a valid/ready handshake to the downstream register or control logic, and reports framing errors with a pulse, a code and a saturating error count.

---
 rtl/uart_cmd_pkg.sv | 28 ++
 rtl/uart_cmd_timeout.sv | 29 ++
 rtl/uart_cmd_sequencer.sv | 112 +++++++++++
 tb/tb_uart_cmd_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types for the UART command sequencer: FSM encoding, error codes, default sync byte.
// Latency: none, declarations only.
// Backpressure: not applicable.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_ISSUE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_CSUM     = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_OVERFLOW = 2'd3
    } err_code_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Frame checksum: 8-bit sum of address and data, carry dropped.
    function automatic logic [7:0] csum8(input logic [7:0] a, input logic [7:0] d);
        return a + d;
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter; expire pulses when the count sits at TIMEOUT_CYCLES-1 while enabled.
// Latency: expire is combinational from the count register, count updates one cycle after en/clr.
// Backpressure: none; clr has priority over en.
module uart_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 87000,
    localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expire = en && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Frames sync/addr/data/csum bytes into register-write commands; inter-byte timeout under UART_CMD_TIMEOUT_EN.
// Latency: cmd_valid rises the cycle after the checksum byte; errors pulse the cycle after detection.
// Backpressure: cmd_valid holds until cmd_ready; bytes arriving meanwhile are dropped as overflow.
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int         CLK_BAUD       = 870,
    parameter int         TIMEOUT_CYCLES = 87000,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data,
    output logic       busy,
    output logic       err_pulse,
    output logic [1:0] err_code,
    output logic [7:0] err_cnt
);

    // Bit timing belongs to the receiver; the parameter is kept so both share one setting.
    if (CLK_BAUD < 1 || TIMEOUT_CYCLES < 2) begin : g_param_range_bad
    end

    state_t     state, state_nxt;
    logic [7:0] addr_q, data_q;
    logic       timeout;
    logic       csum_ok, err_csum, err_ovf, err_any;

`ifdef UART_CMD_TIMEOUT_EN
    logic in_frame;

    assign in_frame = (state == ST_ADDR) || (state == ST_DATA) || (state == ST_CSUM);

    uart_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK    (CLK),
        .RST    (RST),
        .clr    (rx_valid || !in_frame),
        .en     (in_frame && !rx_valid),
        .expire (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    assign csum_ok  = (rx_byte == csum8(addr_q, data_q));
    assign err_csum = (state == ST_CSUM) && rx_valid && !csum_ok;
    assign err_ovf  = (state == ST_ISSUE) && rx_valid;
    assign err_any  = err_csum || err_ovf || timeout;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (rx_valid && rx_byte == SYNC_BYTE) state_nxt = ST_ADDR;
            ST_ADDR:  if (rx_valid) state_nxt = ST_DATA;
                      else if (timeout) state_nxt = ST_IDLE;
            ST_DATA:  if (rx_valid) state_nxt = ST_CSUM;
                      else if (timeout) state_nxt = ST_IDLE;
            ST_CSUM:  if (rx_valid) state_nxt = csum_ok ? ST_ISSUE : ST_IDLE;
                      else if (timeout) state_nxt = ST_IDLE;
            ST_ISSUE: if (cmd_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_valid = (state == ST_ISSUE);
        busy      = (state != ST_IDLE);
    end

    // Command outputs load only on a good checksum so they keep the last accepted command.
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q    <= '0;
            data_q    <= '0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            err_pulse <= 1'b0;
            err_code  <= ERR_NONE;
            err_cnt   <= '0;
        end else begin
            if (state == ST_ADDR && rx_valid) addr_q <= rx_byte;
            if (state == ST_DATA && rx_valid) data_q <= rx_byte;
            if (state == ST_CSUM && rx_valid && csum_ok) begin
                cmd_addr <= addr_q;
                cmd_data <= data_q;
            end
            err_pulse <= err_any;
            if (err_any) begin
                if (err_ovf)       err_code <= ERR_OVERFLOW;
                else if (err_csum) err_code <= ERR_CSUM;
                else               err_code <= ERR_TIMEOUT;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Scoreboard bench for uart_cmd_sequencer; the timeout scenario runs when UART_CMD_TIMEOUT_EN is defined.
module tb_uart_cmd_sequencer;

    localparam int TO = 20;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       busy;
    logic       err_pulse;
    logic [1:0] err_code;
    logic [7:0] err_cnt;

    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_err_cnt = 0;
    logic [15:0] cmd_q[$];
    logic [1:0]  err_q[$];
    logic [15:0] mon_cmd;
    logic [1:0]  mon_err;

    uart_cmd_sequencer #(
        .CLK_BAUD      (870),
        .TIMEOUT_CYCLES(TO),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .busy     (busy),
        .err_pulse(err_pulse),
        .err_code (err_code),
        .err_cnt  (err_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send(8'hA5);
        send(a);
        send(d);
        send(c);
    endtask

    task automatic expect_cmd(input logic [7:0] a, input logic [7:0] d);
        cmd_q.push_back({a, d});
    endtask

    task automatic expect_err(input logic [1:0] c);
        err_q.push_back(c);
        exp_err_cnt++;
    endtask

    // Monitor: every handshake and every error pulse is matched against the queues.
    always @(negedge CLK) begin
        if (!RST) begin
            if (cmd_valid && cmd_ready) begin
                if (cmd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL cmd_unexpected: got %h/%h expected no command", cmd_addr, cmd_data);
                end else begin
                    mon_cmd = cmd_q.pop_front();
                    check("cmd_addr", {24'h0, cmd_addr}, {24'h0, mon_cmd[15:8]});
                    check("cmd_data", {24'h0, cmd_data}, {24'h0, mon_cmd[7:0]});
                end
            end
            if (err_pulse) begin
                if (err_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL err_unexpected: got code %0d expected no error", err_code);
                end else begin
                    mon_err = err_q.pop_front();
                    check("err_code_pulse", {30'h0, err_code}, {30'h0, mon_err});
                end
            end
        end
    end

    initial begin
        tick(3);
        check("rst_cmd_valid", {31'h0, cmd_valid}, 0);
        check("rst_cmd_addr", {24'h0, cmd_addr}, 0);
        check("rst_cmd_data", {24'h0, cmd_data}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_err_pulse", {31'h0, err_pulse}, 0);
        check("rst_err_code", {30'h0, err_code}, 0);
        check("rst_err_cnt", {24'h0, err_cnt}, 0);
        RST = 1'b0;
        cmd_ready = 1'b1;
        tick(1);

        // Good frame, checked for one-cycle latency after the checksum byte.
        expect_cmd(8'h03, 8'h5C);
        send(8'hA5);
        check("busy_after_sync", {31'h0, busy}, 1);
        send(8'h03);
        send(8'h5C);
        send(8'h5F);
        check("latency_cmd_valid", {31'h0, cmd_valid}, 1);
        tick(2);
        check("valid_drops", {31'h0, cmd_valid}, 0);
        check("good_err_cnt", {24'h0, err_cnt}, 0);

        // Bad checksum, then a frame whose checksum wraps.
        expect_err(2'd1);
        frame(8'h03, 8'h5C, 8'h00);
        check("bad_no_valid", {31'h0, cmd_valid}, 0);
        tick(2);
        check("bad_err_code", {30'h0, err_code}, 1);
        check("bad_err_cnt", {24'h0, err_cnt}, 1);
        expect_cmd(8'h10, 8'hF8);
        frame(8'h10, 8'hF8, 8'h08);
        tick(2);

        // Sync value in the address slot is an ordinary address.
        expect_cmd(8'hA5, 8'h01);
        frame(8'hA5, 8'h01, 8'hA6);
        tick(2);

`ifdef UART_CMD_TIMEOUT_EN
        send(8'hA5);
        tick(17);
        send(8'h22);
        check("to_late_byte_ok", {31'h0, busy}, 1);
        expect_err(2'd2);
        tick(19);
        check("to_last_cycle_busy", {31'h0, busy}, 1);
        tick(1);
        check("to_idle", {31'h0, busy}, 0);
        tick(1);
        check("to_err_code", {30'h0, err_code}, 2);
`else
        send(8'hA5);
        tick(30);
        check("no_to_waits", {31'h0, busy}, 1);
        expect_cmd(8'h01, 8'h02);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        tick(2);
`endif

        // Back-pressure for 50 cycles with an overflow byte in the middle.
        cmd_ready = 1'b0;
        expect_cmd(8'h42, 8'h17);
        frame(8'h42, 8'h17, 8'h59);
        for (int i = 0; i < 50; i++) begin
            check("bp_valid", {31'h0, cmd_valid}, 1);
            check("bp_addr", {24'h0, cmd_addr}, 32'h42);
            check("bp_data", {24'h0, cmd_data}, 32'h17);
            if (i == 20) begin
                expect_err(2'd3);
                send(8'h99);
            end else begin
                tick(1);
            end
        end
        check("ovf_err_code", {30'h0, err_code}, 3);
        check("ovf_still_busy", {31'h0, busy}, 1);
        cmd_ready = 1'b1;
        tick(1);
        check("bp_done_valid", {31'h0, cmd_valid}, 0);
        check("bp_hold_addr", {24'h0, cmd_addr}, 32'h42);

        // Byte and ready in the same ISSUE cycle: delivered, and still an overflow.
        cmd_ready = 1'b0;
        expect_cmd(8'h5A, 8'h01);
        frame(8'h5A, 8'h01, 8'h5B);
        tick(2);
        cmd_ready = 1'b1;
        expect_err(2'd3);
        send(8'h77);
        check("same_cycle_idle", {31'h0, busy}, 0);
        tick(2);
        check("same_cycle_code", {30'h0, err_code}, 3);

        // Reset mid-frame abandons the frame silently.
        send(8'hA5);
        send(8'h07);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        exp_err_cnt = 0;
        send(8'h5C);
        send(8'h63);
        tick(3);
        check("mid_rst_err_cnt", {24'h0, err_cnt}, 0);
        check("mid_rst_idle", {31'h0, busy}, 0);
        expect_cmd(8'h07, 8'h5C);
        frame(8'h07, 8'h5C, 8'h63);
        tick(2);

        // Saturation of the error counter.
        for (int i = 0; i < 260; i++) begin
            expect_err(2'd1);
            frame(8'h01, 8'h01, 8'h00);
        end
        tick(3);
        check("sat_err_cnt", {24'h0, err_cnt}, (exp_err_cnt > 255) ? 255 : exp_err_cnt);

        tick(5);
        check("cmd_q_drained", cmd_q.size(), 0);
        check("err_q_drained", err_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
